// File: rtl/mem_arb_pkg.sv
// Shared encodings and default widths for the memory arbiter and Main_Memory.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_D = 1'b0,
        OWN_I = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requests.
// Tie policy: fixed data priority, or round-robin when MEM_ARB_ROUND_ROBIN_EN is defined.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
    input  owner_t last_grant,
    output logic   grant,
    output owner_t winner
);

    owner_t tie_winner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Favour whichever port did not win the previous grant.
    assign tie_winner = (last_grant == OWN_D) ? OWN_I : OWN_D;
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign tie_winner        = OWN_D;
`endif

    always_comb begin
        grant  = if_req | d_req;
        winner = OWN_D;
        if (if_req && !d_req) begin
            winner = OWN_I;
        end else if (if_req && d_req) begin
            winner = tie_winner;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer sharing one Main_Memory port between fetch and data paths.
// Tie-break policy selected by MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_dataIn,
    input  logic [DATA_W-1:0] mem_dataOut,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_instruction,
    input  logic              mem_done,
    output logic              busy,
    output state_t            dbg_state
);

    // Handshake: a requester holds req and its fields until its one-cycle ack,
    // dropping req at the edge that ends the ack cycle; req high in IDLE is a new request.

    state_t            state_q, state_d;
    owner_t            owner_q, last_q, winner;
    logic              grant, load, capture, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    mem_arb_pick u_pick (
        .if_req    (if_req),
        .d_req     (d_req),
        .last_grant(last_q),
        .grant     (grant),
        .winner    (winner)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    load    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (mem_done) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q  <= OWN_D;
            last_q   <= OWN_D;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            if (load) begin
                owner_q <= winner;
                last_q  <= winner;
                // The fetch port is read-only, so its write enable is forced low.
                we_q    <= (winner == OWN_D) && d_we;
                addr_q  <= (winner == OWN_I) ? if_addr : d_addr;
                wdata_q <= (winner == OWN_D) ? d_wdata : '0;
            end
            if (capture) begin
                if (owner_q == OWN_I) if_rdata <= mem_dataOut;
                else                  d_rdata  <= mem_dataOut;
            end
        end
    end

    assign mem_read        = (state_q == ISSUE) && !we_q;
    assign mem_write       = (state_q == ISSUE) && we_q;
    assign mem_address     = addr_q;
    assign mem_dataIn      = wdata_q;
    assign mem_instruction = (state_q != IDLE) && (owner_q == OWN_I);
    assign busy            = (state_q != IDLE);
    assign if_ack          = (state_q == RESP) && (owner_q == OWN_I);
    assign d_ack           = (state_q == RESP) && (owner_q == OWN_D);
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against
// a transaction-level reference model. Honours MEM_ARB_ROUND_ROBIN_EN like the design.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 13;
    localparam int DW = 13;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, d_req, d_we, mem_done;
    logic [AW-1:0] if_addr, d_addr, mem_address;
    logic [DW-1:0] d_wdata, mem_dataOut, if_rdata, d_rdata, mem_dataIn;
    logic          if_ack, d_ack, mem_read, mem_write, mem_instruction, busy;
    state_t        dbg_state;

    int n_vec  = 0;
    int n_fail = 0;

    // Memory contents seen by the bench's memory responder, and the model's own copy.
    logic [DW-1:0] mem_array [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem   [0:(1<<AW)-1];
    logic          model_last_i;
    logic [DW-1:0] prev_if_rdata, prev_d_rdata;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_rdata       (if_rdata),
        .if_ack         (if_ack),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_rdata        (d_rdata),
        .d_ack          (d_ack),
        .mem_address    (mem_address),
        .mem_dataIn     (mem_dataIn),
        .mem_dataOut    (mem_dataOut),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_instruction(mem_instruction),
        .mem_done       (mem_done),
        .busy           (busy),
        .dbg_state      (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        model_last_i  = 1'b0;
        prev_if_rdata = '0;
        prev_d_rdata  = '0;
    endtask

    // Winner rule: lone requester wins; ties go to data, or alternate under round-robin.
    function automatic logic model_pick_i(input logic ireq, input logic dreq);
        if (ireq && !dreq) return 1'b1;
        if (!ireq) return 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return !model_last_i;
`else
        return 1'b0;
`endif
    endfunction

    task automatic apply_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) step();
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    // Runs one access starting in IDLE with request inputs already applied.
    task automatic do_access(input int n_wait, input bit stray, input bit hold);
        logic          own_i, exp_we;
        logic [AW-1:0] exp_addr, resp_addr;
        logic [DW-1:0] exp_rd;
        own_i    = model_pick_i(if_req, d_req);
        exp_we   = !own_i && d_we;
        exp_addr = own_i ? if_addr : d_addr;
        exp_rd   = exp_we ? d_wdata : ref_mem[exp_addr];
        if (exp_we) ref_mem[exp_addr] = d_wdata;
        model_last_i = own_i;

        mem_done    = stray;
        mem_dataOut = DW'($urandom);
        step();
        check_eq("issue_busy", busy, 1);
        check_eq("issue_rd", mem_read, !exp_we);
        check_eq("issue_wr", mem_write, exp_we);
        check_eq("issue_addr", mem_address, exp_addr);
        check_eq("issue_instr", mem_instruction, own_i);
        if (exp_we) check_eq("issue_wdata", mem_dataIn, d_wdata);
        check_eq("issue_ack", {if_ack, d_ack}, 0);
        resp_addr = mem_address;
        if (mem_write) mem_array[mem_address] = mem_dataIn;
        step();

        for (int i = 0; i <= n_wait; i++) begin
            check_eq("wait_strobe", {mem_read, mem_write}, 0);
            check_eq("wait_addr", mem_address, exp_addr);
            check_eq("wait_instr", mem_instruction, own_i);
            check_eq("wait_busy", busy, 1);
            check_eq("wait_ack", {if_ack, d_ack}, 0);
            if (i == n_wait) begin
                mem_done    = 1'b1;
                mem_dataOut = mem_array[resp_addr];
            end else begin
                mem_done    = 1'b0;
                mem_dataOut = DW'($urandom);
            end
            step();
        end
        mem_done    = 1'b0;
        mem_dataOut = DW'($urandom);

        check_eq("resp_if_ack", if_ack, own_i);
        check_eq("resp_d_ack", d_ack, !own_i);
        check_eq("resp_if_rdata", if_rdata, own_i ? exp_rd : prev_if_rdata);
        check_eq("resp_d_rdata", d_rdata, own_i ? prev_d_rdata : exp_rd);
        if (own_i) prev_if_rdata = exp_rd;
        else       prev_d_rdata  = exp_rd;
        if (!hold) begin
            if_req = 1'b0;
            d_req  = 1'b0;
        end
        step();
        check_eq("idle_busy", busy, 0);
        check_eq("idle_ack", {if_ack, d_ack}, 0);
    endtask

    initial begin
        int r;
        reset       = 1'b0;
        if_req      = 1'b1;
        d_req       = 1'b1;
        d_we        = 1'b0;
        if_addr     = '0;
        d_addr      = '0;
        d_wdata     = '0;
        mem_done    = 1'b0;
        mem_dataOut = '0;
        model_reset();
        for (int i = 0; i < 32; i++) begin
            mem_array[i] = DW'(i * 37 + 5);
            ref_mem[i]   = DW'(i * 37 + 5);
        end

        // Reset held with both requests pending.
        repeat (3) step();
        check_eq("rst_if_rdata", if_rdata, 0);
        check_eq("rst_d_rdata", d_rdata, 0);
        check_eq("rst_ack", {if_ack, d_ack}, 0);
        check_eq("rst_ctrl", {mem_read, mem_write, mem_instruction, busy}, 0);
        check_eq("rst_addr", mem_address, 0);
        check_eq("rst_dataIn", mem_dataIn, 0);
        check_eq("rst_state", dbg_state, IDLE);
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step();

        // Data write, done two cycles after the strobe.
        d_req = 1'b1; d_we = 1'b1; d_addr = 13'h005; d_wdata = 13'h0F0F;
        do_access(1, 1'b0, 1'b0);

        // Fetch, done in the first WAIT cycle.
        mem_array[13'h010] = 13'h1ABC;
        ref_mem[13'h010]   = 13'h1ABC;
        if_req = 1'b1; if_addr = 13'h010;
        do_access(0, 1'b0, 1'b0);

        // Tie with both requests held, starting from reset.
        apply_reset();
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 13'h003; if_addr = 13'h007;
        repeat (4) do_access(0, 1'b0, 1'b1);
        if_req = 1'b0;
        d_req  = 1'b0;
        step();

        // Reset asserted in WAIT of a data read; held request is reissued afterwards.
        d_req = 1'b1; d_we = 1'b0; d_addr = 13'h009;
        step();
        step();
        reset = 1'b0;
        #1;
        check_eq("arst_rd", mem_read, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_ack", {if_ack, d_ack}, 0);
        mem_done = 1'b1;
        repeat (2) begin
            step();
            check_eq("arst_hold_ack", {if_ack, d_ack, busy}, 0);
        end
        mem_done = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        do_access(0, 1'b0, 1'b0);

        // Stray done in IDLE, then during IDLE/ISSUE of real accesses.
        mem_done = 1'b1;
        repeat (2) begin
            step();
            check_eq("stray_idle", {busy, if_ack, d_ack}, 0);
        end
        mem_done = 1'b0;
        if_req = 1'b1; if_addr = 13'h012;
        do_access(1, 1'b1, 1'b0);
        d_req = 1'b1; d_we = 1'b1; d_addr = 13'h004; d_wdata = 13'h1234;
        do_access(2, 1'b1, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            r       = $urandom_range(1, 3);
            if_req  = r[0];
            d_req   = r[1];
            if_addr = AW'($urandom_range(0, 31));
            d_addr  = AW'($urandom_range(0, 31));
            d_we    = 1'($urandom_range(0, 1));
            d_wdata = DW'($urandom);
            do_access($urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of `Main_Memory`. It shares the single memory port between the instruction-fetch path (read-only) and the data path (read/write). It serialises accesses through a four-state FSM, drives the memory's `read`/`write`/`instruction` strobes, and returns read data to the winning requester with a one-cycle `ack`. It sits between `Control`/datapath and `Main_Memory`.

## Interface
- `ADDR_W`, default 13: address width.
- `DATA_W`, default 13: data width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `if_req` in 1: instruction fetch request (level).
- `if_addr` in ADDR_W: fetch address.
- `if_rdata` out DATA_W: fetched word; valid while `if_ack`=1.
- `if_ack` out 1: one-cycle completion pulse for the fetch port.
- `d_req` in 1: data request (level).
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: write data.
- `d_rdata` out DATA_W: read word; valid while `d_ack`=1.
- `d_ack` out 1: one-cycle completion pulse for the data port.
- `mem_address` out ADDR_W: to `Main_Memory` address.
- `mem_dataIn` out DATA_W: to `Main_Memory` dataIn.
- `mem_dataOut` in DATA_W: from `Main_Memory` dataOut.
- `mem_read`, `mem_write` out 1: memory strobes.
- `mem_instruction` out 1: 1 while the fetch port owns the memory.
- `mem_done` in 1: memory `Done`.
- `busy` out 1: 1 whenever state ≠ IDLE.

## Operation
- States: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE**
  - If any request is pending, pick a winner.
  - Latch owner, address, write data and `we` into registers. The fetch port's `we` is forced to 0.
  - Go to ISSUE.
  - With no request, stay in IDLE.
- **ISSUE**
  - Assert exactly one of `mem_read`/`mem_write` for exactly one cycle.
  - Drive the latched address and data.
  - Go to WAIT.
- **WAIT**
  - Hold address, data and `mem_instruction`. Both strobes are 0.
  - On `mem_done`=1, capture `mem_dataOut` into the read register and go to RESP.
  - There is no timeout.
- **RESP**
  - Pulse the owner's `ack` for one cycle. Its `rdata` carries the captured word.
  - For writes, `rdata` is the value read back on `mem_dataOut`.
  - Return to IDLE.
- **Arbitration:** a lone requester always wins. A tie is resolved per Configuration.
- **Requester contract**
  - Hold `req` and its fields stable until `ack`.
  - Drop `req` at the edge that ends the `ack` cycle.
  - A `req` still high in IDLE is a new request.
- A `req` that falls before `ack` does not abort the access; it completes and is acked.
- `mem_done` outside WAIT is ignored.
- The non-owner's `ack` is 0 and its `rdata` holds its previous value.

## Timing
- Reset values:
  - All outputs are 0, including `mem_address`, `mem_dataIn`, both `rdata`, `busy` and `mem_instruction`.
  - The FSM is in IDLE. The round-robin pointer holds data-last-granted.
- Reset assertion mid-transaction:
  - The state returns to IDLE immediately and asynchronously.
  - `mem_read`/`mem_write`/`ack` drop without waiting for a clock.
  - No `ack` is issued for the abandoned access.
- Latency:
  - Request sampled in IDLE at cycle 0.
  - Strobe in cycle 1.
  - WAIT from cycle 2.
  - `ack` in cycle N+3, where N = number of WAIT cycles before `mem_done` (N=0 if `done` arrives in the first WAIT cycle).
  - Minimum is ack in cycle 3.
- Throughput: back-to-back accesses are 4 cycles apart minimum, because IDLE costs one cycle.
- `busy` rises in cycle 1 and falls after RESP.

## Configuration
- Macro: `MEM_ARB_ROUND_ROBIN_EN`.
- **Without the macro:** fixed priority, data beats instruction on a tie.
- **With the macro:**
  - A 1-bit last-grant register toggles priority on ties, favouring the port not granted last.
  - Reset value is data, so the first tie goes to instruction.
  - The register updates on every grant, tie or not.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3);
  - the owner encoding (OWN_D=0, OWN_I=1);
  - the `ADDR_W`/`DATA_W` defaults, shared with `Main_Memory`.
- One sub-module, `mem_arb_pick`: combinational winner selection from `if_req`, `d_req` and last-grant. It contains all macro-dependent logic.

## Test plan
1. **Reset:** hold `reset`=0 with `if_req`=`d_req`=1 → all outputs 0, no strobes, `busy`=0.
2. **Data write:** `d_req`=1, `d_we`=1, `d_addr`=0x005, `d_wdata`=0x0F0F, `mem_done` 2 cycles after the strobe → one-cycle `mem_write` with `mem_address`=0x005 and `mem_dataIn`=0x0F0F, then `d_ack` one cycle after `done`, `mem_instruction`=0.
3. **Fetch:** `if_req`=1, `if_addr`=0x010, memory returns 0x1ABC with `done` in the first WAIT cycle → `mem_read` plus `mem_instruction`=1, then `if_ack` in cycle 3 with `if_rdata`=0x1ABC.
4. **Tie:** `if_req`=`d_req`=1 held, 4 accesses.
   - Without the macro: order D, D, D, D while `d_req` stays high.
   - With `MEM_ARB_ROUND_ROBIN_EN`: order I, D, I, D.
5. **Reset mid-WAIT:** assert `reset` during WAIT of a read → `mem_read`/`busy` are 0 immediately and no `ack` is issued. After release, a still-held `req` is reissued from IDLE.
6. **Stray done:** pulse `mem_done` in IDLE and ISSUE → no state change, no `ack`. Completion waits for a `done` in WAIT.
